// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request controller.
//   fetch_state_e   : request FSM states
//   FETCH_WORD_INCR : byte increment between sequential word fetches
//   FETCH_WORD_MASK : clears addr[1:0] to form a word-aligned bus address
//   word_align()    : applies FETCH_WORD_MASK
package ibex_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_IDLE,
    FETCH_WAIT_GNT
  } fetch_state_e;

  localparam logic [31:0] FETCH_WORD_INCR = 32'd4;
  localparam logic [31:0] FETCH_WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(logic [31:0] addr);
    return addr & FETCH_WORD_MASK;
  endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// Instruction bus (req/gnt/rvalid protocol) between the fetch request controller and memory.
//   req/addr                : request and word address, driven by the master
//   gnt                     : grant, driven by the slave
//   rvalid/rdata/err        : response, driven by the slave
interface ibex_fetch_req_ctrl_if;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/ibex_fetch_outstanding.sv
// Outstanding / discard tracker for in-flight instruction bus requests.
// Both vectors are thermometers with bit 0 the oldest request.
//   clk_i, rst_ni        : clock, async active-low reset
//   gnt_i                : a request is granted this cycle
//   gnt_discard_i        : the request granted this cycle is already stale
//   rvalid_i             : the oldest request's response arrives this cycle
//   branch_i             : redirect; every request already in flight becomes stale
//   outstanding_o        : registered outstanding vector
//   outstanding_next_o   : outstanding vector as it will be next cycle
//   discard_o            : registered discard vector
module ibex_fetch_outstanding #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                gnt_i,
  input  logic                gnt_discard_i,
  input  logic                rvalid_i,
  input  logic                branch_i,
  output logic [NUM_REQS-1:0] outstanding_o,
  output logic [NUM_REQS-1:0] outstanding_next_o,
  output logic [NUM_REQS-1:0] discard_o
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] out_shift, dis_shift, new_bit;

  // Retire first, then allocate, so a same-cycle grant lands in the slot just freed.
  always_comb begin
    out_shift     = rvalid_i ? (outstanding_q >> 1) : outstanding_q;
    dis_shift     = rvalid_i ? (discard_q >> 1) : discard_q;
    new_bit       = gnt_i ? (~out_shift & {out_shift[NUM_REQS-2:0], 1'b1}) : '0;
    outstanding_d = out_shift | new_bit;
    discard_d     = dis_shift | (gnt_discard_i ? new_bit : '0) | (branch_i ? out_shift : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign outstanding_o      = outstanding_q;
  assign outstanding_next_o = outstanding_d;
  assign discard_o          = discard_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Request-side controller for the 32-bit instruction bus, feeding the fetch FIFO.
// Issues word-aligned requests, tracks up to NUM_REQS responses in flight, drops responses
// made stale by a branch and throttles requests on the FIFO's fill status.
//   clk_i, rst_ni    : clock, async active-low reset
//   req_i            : fetch enable from the core
//   branch_i, addr_i : redirect and its (halfword aligned) target
//   fifo_busy_i      : fill status of the upper FIFO entries
//   fifo_*_o         : FIFO push port (clear, valid, addr, rdata, err)
//   instr            : instruction bus, master side
//   busy_o           : any request outstanding or waiting for grant
// Optional: define IBEX_FETCH_ERR_STOP_EN to stop fetching after an erroring response
// until the next branch.
module ibex_fetch_req_ctrl
  import ibex_fetch_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [31:0]           addr_i,
  input  logic [NUM_REQS-1:0]   fifo_busy_i,
  output logic                  fifo_clear_o,
  output logic                  fifo_valid_o,
  output logic [31:0]           fifo_addr_o,
  output logic [31:0]           fifo_rdata_o,
  output logic                  fifo_err_o,
  ibex_fetch_req_ctrl_if.master instr,
  output logic                  busy_o
);

  fetch_state_e        state_q;
  logic [31:0]         fetch_addr_q, stored_addr_q, stored_branch_q;
  logic                branch_pending_q;

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d, discard_q, busy_rev;
  logic [31:0]         branch_addr, addr_out;
  logic                req_out, grant, stale_gnt, live_gnt;
  logic                fifo_ready, full, fetch_block, valid_new_req, fifo_push;

  assign branch_addr = word_align(addr_i);

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr.rdata;
  assign fifo_err_o   = instr.err;
  assign fifo_push    = instr.rvalid & ~discard_q[0] & ~branch_i;
  assign fifo_valid_o = fifo_push;

  // One FIFO slot is reserved per outstanding request; the oldest maps to the highest slot.
  always_comb begin
    busy_rev = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      busy_rev[i] = outstanding_q[NUM_REQS-1-i];
    end
  end

  assign fifo_ready    = ~&(fifo_busy_i | busy_rev);
  assign full          = outstanding_q[NUM_REQS-1] & ~instr.rvalid;
  assign valid_new_req = req_i & (fifo_ready | branch_i) & ~full & ~fetch_block;

`ifdef IBEX_FETCH_ERR_STOP_EN
  logic err_stop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_stop_q <= 1'b0;
    end else if (branch_i) begin
      err_stop_q <= 1'b0;
    end else if (fifo_push && instr.err) begin
      err_stop_q <= 1'b1;
    end
  end

  // The clearing branch may itself start the new fetch.
  assign fetch_block = err_stop_q & ~branch_i;
`else
  assign fetch_block = 1'b0;
`endif

  always_comb begin
    req_out  = 1'b0;
    addr_out = fetch_addr_q;
    unique case (state_q)
      FETCH_IDLE: begin
        req_out  = valid_new_req;
        addr_out = branch_i ? branch_addr : fetch_addr_q;
      end
      FETCH_WAIT_GNT: begin
        req_out  = 1'b1;
        addr_out = stored_addr_q;
      end
      default: ;
    endcase
  end

  assign instr.req  = req_out;
  assign instr.addr = addr_out;

  // A request held across a branch is still granted, but its response is dropped.
  assign grant     = req_out & instr.gnt;
  assign stale_gnt = (state_q == FETCH_WAIT_GNT) & (branch_pending_q | branch_i);
  assign live_gnt  = grant & ~stale_gnt;

  ibex_fetch_outstanding #(
    .NUM_REQS (NUM_REQS)
  ) u_outstanding (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .gnt_i              (grant),
    .gnt_discard_i      (stale_gnt),
    .rvalid_i           (instr.rvalid),
    .branch_i           (branch_i),
    .outstanding_o      (outstanding_q),
    .outstanding_next_o (outstanding_d),
    .discard_o          (discard_q)
  );

  logic unused_outstanding_d;
  assign unused_outstanding_d = ^{outstanding_d[NUM_REQS-2:0], discard_q[NUM_REQS-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= FETCH_IDLE;
      fetch_addr_q     <= '0;
      stored_addr_q    <= '0;
      stored_branch_q  <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      if (branch_i && !live_gnt) begin
        fetch_addr_q <= branch_addr;
      end else if (live_gnt) begin
        fetch_addr_q <= addr_out + FETCH_WORD_INCR;
      end

      unique case (state_q)
        FETCH_IDLE: begin
          branch_pending_q <= 1'b0;
          if (req_out && !instr.gnt) begin
            state_q       <= FETCH_WAIT_GNT;
            stored_addr_q <= addr_out;
          end
        end
        FETCH_WAIT_GNT: begin
          if (instr.gnt) begin
            branch_pending_q <= 1'b0;
            // Re-issue at the branch target straight away unless the tracker is now full,
            // in which case IDLE picks it up from fetch_addr_q once a slot frees.
            if ((branch_pending_q || branch_i) && !outstanding_d[NUM_REQS-1]) begin
              stored_addr_q <= branch_i ? branch_addr : stored_branch_q;
            end else begin
              state_q <= FETCH_IDLE;
            end
          end else if (branch_i) begin
            stored_branch_q  <= branch_addr;
            branch_pending_q <= 1'b1;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign busy_o = (|outstanding_q) | (state_q == FETCH_WAIT_GNT);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scoreboard bench for ibex_fetch_req_ctrl (NUM_REQS = 2): stimulus pushes expected grant
// addresses and FIFO pushes into queues; a monitor pops and compares on every grant / push.
module tb_ibex_fetch_req_ctrl;

  localparam int unsigned NumReqs = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               req_i = 1'b0;
  logic               branch_i = 1'b0;
  logic [31:0]        addr_i = '0;
  logic [NumReqs-1:0] fifo_busy_i = '0;
  logic               fifo_clear_o, fifo_valid_o, fifo_err_o, busy_o;
  logic [31:0]        fifo_addr_o, fifo_rdata_o;

  ibex_fetch_req_ctrl_if bus ();

  ibex_fetch_req_ctrl #(
    .NUM_REQS (NumReqs)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .branch_i     (branch_i),
    .addr_i       (addr_i),
    .fifo_busy_i  (fifo_busy_i),
    .fifo_clear_o (fifo_clear_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_addr_o  (fifo_addr_o),
    .fifo_rdata_o (fifo_rdata_o),
    .fifo_err_o   (fifo_err_o),
    .instr        (bus),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_addr[$];
  rsp_t        exp_rsp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic b, input logic [31:0] a, input logic g,
                     input logic v, input logic [31:0] d, input logic e);
    req_i      = r;
    branch_i   = b;
    addr_i     = a;
    bus.gnt    = g;
    bus.rvalid = v;
    bus.rdata  = d;
    bus.err    = e;
  endtask

  task automatic exp_gnt(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic exp_push(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_rsp.push_back(r);
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every grant and every FIFO push must match the head of its queue.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.req && bus.gnt) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_grant", bus.addr, 32'hXXXX_XXXX);
        end else begin
          chk("grant_addr", bus.addr, exp_addr.pop_front());
        end
      end
      if (fifo_valid_o) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_push", fifo_rdata_o, 32'hXXXX_XXXX);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("push_rdata", fifo_rdata_o, r.data);
          chk("push_err", {31'd0, fifo_err_o}, {31'd0, r.err});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    next_cyc();
    rst_ni = 1'b1;

    // Branch with same-cycle grant, then sequential fetch until full.
    drv(1, 1, 32'h0000_1002, 1, 0, 0, 0); exp_gnt(32'h0000_1000);
    @(negedge clk_i);
    chk("br_clear", {31'd0, fifo_clear_o}, 32'd1);
    chk("br_fifo_addr", fifo_addr_o, 32'h0000_1002);
    chk("br_bus_addr", bus.addr, 32'h0000_1000);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_1004);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0);
    @(negedge clk_i);
    chk("full_no_req", {31'd0, bus.req}, 32'd0);
    chk("full_busy", {31'd0, busy_o}, 32'd1);
    next_cyc();
    drv(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0); exp_push(32'hDEAD_BEEF, 0);
    next_cyc();
    // Request at 0x1008 left ungranted: held for three cycles regardless of inputs.
    drv(1, 0, 0, 0, 1, 32'h1111_2222, 0); exp_push(32'h1111_2222, 0);
    @(negedge clk_i);
    chk("wait_req0", {31'd0, bus.req}, 32'd1);
    chk("wait_addr0", bus.addr, 32'h0000_1008);
    next_cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("wait_req1", {31'd0, bus.req}, 32'd1);
    chk("wait_addr1", bus.addr, 32'h0000_1008);
    next_cyc();
    fifo_busy_i = 2'b11;
    @(negedge clk_i);
    chk("wait_req2", {31'd0, bus.req}, 32'd1);
    chk("wait_addr2", bus.addr, 32'h0000_1008);
    next_cyc();
    fifo_busy_i = 2'b00;
    drv(0, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_1008);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'h3333_4444, 0); exp_push(32'h3333_4444, 0);
    @(negedge clk_i);
    chk("idle_after_gnt", {31'd0, bus.req}, 32'd0);
    next_cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("drained_busy", {31'd0, busy_o}, 32'd0);
    next_cyc();

    // Two outstanding, branch to 0x200: both old responses dropped.
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_100C);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_1010);
    next_cyc();
    drv(1, 1, 32'h0000_0200, 1, 0, 0, 0);
    @(negedge clk_i);
    chk("br_full_no_req", {31'd0, bus.req}, 32'd0);
    next_cyc();
    drv(1, 0, 0, 0, 1, 32'hBAD0_0001, 0);
    next_cyc();
    drv(1, 0, 0, 1, 1, 32'hBAD0_0002, 0); exp_gnt(32'h0000_0200);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'h0200_0200, 0); exp_push(32'h0200_0200, 0);
    next_cyc();

    // Branch to 0x80 while 0x40 waits for grant.
    drv(1, 1, 32'h0000_0040, 0, 0, 0, 0);
    next_cyc();
    drv(1, 1, 32'h0000_0080, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("wg_branch_hold", bus.addr, 32'h0000_0040);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_0040);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_0080);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'hDEAD_0040, 0);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'h0080_0080, 0); exp_push(32'h0080_0080, 0);
    next_cyc();

    // Erroring response.
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_0084);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'hE0E0_E0E0, 1); exp_push(32'hE0E0_E0E0, 1);
    @(negedge clk_i);
    chk("err_forward", {31'd0, fifo_err_o}, 32'd1);
    next_cyc();
`ifdef IBEX_FETCH_ERR_STOP_EN
    drv(1, 0, 0, 1, 0, 0, 0);
    @(negedge clk_i);
    chk("err_stop0", {31'd0, bus.req}, 32'd0);
    next_cyc();
    @(negedge clk_i);
    chk("err_stop1", {31'd0, bus.req}, 32'd0);
    next_cyc();
`else
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_0088);
    @(negedge clk_i);
    chk("err_continue", {31'd0, bus.req}, 32'd1);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'h0088_0088, 0); exp_push(32'h0088_0088, 0);
    next_cyc();
`endif
    drv(1, 1, 32'h0000_0300, 1, 0, 0, 0); exp_gnt(32'h0000_0300);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'h0300_0300, 0); exp_push(32'h0300_0300, 0);
    next_cyc();

    // Address wrap-around.
    drv(1, 1, 32'hFFFF_FFFE, 1, 0, 0, 0); exp_gnt(32'hFFFF_FFFC);
    next_cyc();
    drv(1, 0, 0, 1, 0, 0, 0); exp_gnt(32'h0000_0000);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'hAAAA_0001, 0); exp_push(32'hAAAA_0001, 0);
    next_cyc();
    drv(0, 0, 0, 0, 1, 32'hAAAA_0002, 0); exp_push(32'hAAAA_0002, 0);
    next_cyc();

    // FIFO full throttles requests.
    drv(1, 0, 0, 0, 0, 0, 0);
    fifo_busy_i = 2'b11;
    @(negedge clk_i);
    chk("fifo_throttle", {31'd0, bus.req}, 32'd0);
    next_cyc();

    // Reset while waiting for grant at 0x4.
    fifo_busy_i = 2'b00;
    next_cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    chk("pre_rst_addr", bus.addr, 32'h0000_0004);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_req", {31'd0, bus.req}, 32'd0);
    chk("mid_rst_addr", bus.addr, 32'd0);
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();

    chk("addr_queue_empty", exp_addr.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
